fill_responder: RTL and testbench
=================================

Name: fill_responder

Overview:
- Channel-side counterpart of the trigger manager's prepare/go/pause/ready/done handshake.
- On `prepare`, the block arms the channel for PREP_CYCLES cycles, then reports `ready`.
- On `go` (with `pause` high), it captures `fill_len` samples into local buffer addresses, then holds `done` until the manager drops `go`.
- One instance per digitizer channel, between the trigger manager and the sample buffer.

Parameters:
PREP_CYCLES, 16, arming delay in clk cycles from accepted prepare to ready; legal range 1..65535
LEN_W, 16, width of fill_len, sample counter and sample_addr
CNT_W, 16, width of fill_count

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
prepare  in  1  manager request to arm channel (level)
go  in  1  manager fill enable (level)
pause  in  1  manager pause flag; high for the whole fill
fill_len  in  LEN_W  samples per fill; sampled when prepare is accepted
sample_valid  in  1  ADC sample strobe
err_clr  in  1  clears sticky err
ready  out  1  channel armed (registered)
done  out  1  fill complete (registered)
busy  out  1  state != IDLE
sample_we  out  1  buffer write enable
sample_addr  out  LEN_W  buffer write address
fill_count  out  CNT_W  completed fills, wraps modulo 2^CNT_W
err  out  1  sticky protocol-error flag

Behaviour:
Reset:
- State IDLE.
- ready, done, busy, sample_we, err all 0.
- sample_addr, fill_count, internal counters all 0.
- Reset asserted mid-operation returns the block to IDLE immediately; no done is produced.

States: IDLE, ARM, READY, FILL, DONE.
- IDLE:
  - prepare=1 → ARM; latch fill_len; load prep counter with PREP_CYCLES-1.
  - go=1 while prepare=0 → set err, stay IDLE.
- ARM:
  - prepare=0 → IDLE (abort, no err).
  - Otherwise, counter==0 → READY; else decrement.
  - go=1 → set err; it has no other effect.
  - Latency: prepare sampled at edge k gives ready high after edge k+PREP_CYCLES.
- READY (ready=1):
  - go=1 and pause=1:
    - Latched length 0 → DONE, with no writes.
    - Otherwise → FILL, with sample counter cleared to 0.
  - go=1 and pause=0 → set err, stay READY.
  - prepare=0 and go=0 → IDLE (abort, no err).
- FILL:
  - sample_we = sample_valid & go; combinational.
  - sample_addr = sample counter.
  - Each write increments the counter.
  - A write with counter == len-1 → DONE; fill_count += 1 on that edge.
  - go=0 before completion → IDLE; set err; partial data is left in the buffer; fill_count unchanged.
  - pause=0 while go=1 → set err; filling continues.
- DONE (done=1):
  - Hold done while go=1.
  - go=0 → IDLE; done drops on that edge.
  - A zero-length fill also increments fill_count on DONE entry.

Rules:
- ready and done are decoded from registered state, glitch-free, never high together.
- sample_valid outside FILL is ignored.
- prepare re-asserted while in DONE is ignored until IDLE is reached.
- err is set by any violation listed above and cleared only by err_clr.
- If set and clear occur in the same cycle, set wins.
- busy = (state != IDLE).

Test Plan:
1. PREP_CYCLES=4, fill_len=3, prepare high at edge 0 → ready=1 after edge 4. Then go=pause=1 with sample_valid continuous → writes at addr 0,1,2 → done=1 on the next edge; go=0 → done=0 next edge; fill_count=1, err=0.
2. fill_len=5, sample_valid toggling every other cycle → exactly 5 writes, addr 0..4; done only after the 5th valid; no write while sample_valid=0.
3. Abort cases:
   - prepare dropped after 2 cycles of ARM → IDLE; ready never asserts; err=0.
   - go dropped in FILL after 2 of 8 samples → IDLE; err=1; fill_count unchanged; err_clr → err=0.
4. fill_len=0 → go=pause=1 in READY → DONE next edge with zero sample_we pulses; fill_count increments.
5. Protocol errors:
   - go=1 in IDLE → err=1, state stays IDLE.
   - go=1 with pause=0 in READY → err=1, no FILL entry.
6. Reset and wrap:
   - rst_n low mid-FILL → all outputs 0 asynchronously.
   - CNT_W=2, run 5 fills → fill_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fill_responder_if.sv
// Channel-side bundle of the trigger-manager handshake and the sample-buffer
// write port. The manager (or a bench) drives the master side; the
// fill_responder drives the slave side.
interface fill_responder_if #(
    parameter int LEN_W = 16,
    parameter int CNT_W = 16
);
    logic             prepare;
    logic             go;
    logic             pause;
    logic [LEN_W-1:0] fill_len;
    logic             sample_valid;
    logic             err_clr;
    logic             ready;
    logic             done;
    logic             busy;
    logic             sample_we;
    logic [LEN_W-1:0] sample_addr;
    logic [CNT_W-1:0] fill_count;
    logic             err;

    modport master (
        output prepare, go, pause, fill_len, sample_valid, err_clr,
        input  ready, done, busy, sample_we, sample_addr, fill_count, err
    );

    modport slave (
        input  prepare, go, pause, fill_len, sample_valid, err_clr,
        output ready, done, busy, sample_we, sample_addr, fill_count, err
    );
endinterface

// File: rtl/fill_responder.sv
// Per-channel fill responder: arms on prepare, reports ready after the
// arming delay, captures fill_len samples while go is held, then holds done
// until the manager releases go. Protocol violations latch a sticky err.
module fill_responder #(
    parameter int PREP_CYCLES = 16,
    parameter int LEN_W       = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fill_responder_if.slave   ch_if
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_READY = 3'd2,
        ST_FILL  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Counter is loaded with PREP_CYCLES-1 so READY is entered exactly
    // PREP_CYCLES edges after prepare is accepted.
    localparam logic [15:0] PREP_LOAD = 16'(PREP_CYCLES - 1);

    state_t           state_q;
    logic [15:0]      prep_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] smp_cnt_q;
    logic [CNT_W-1:0] fill_cnt_q;
    logic             err_q;

    logic             write_s;
    logic             last_s;
    logic             viol_s;

    assign write_s = (state_q == ST_FILL) && ch_if.sample_valid && ch_if.go;
    assign last_s  = (smp_cnt_q == (len_q - LEN_W'(1)));

    // Protocol-violation detect for the current state and manager inputs.
    always_comb begin
        viol_s = 1'b0;
        case (state_q)
            ST_IDLE:  viol_s = ch_if.go && !ch_if.prepare;
            ST_ARM:   viol_s = ch_if.go;
            ST_READY: viol_s = ch_if.go && !ch_if.pause;
            ST_FILL:  viol_s = !ch_if.go || !ch_if.pause;
            ST_DONE:  viol_s = 1'b0;
            default:  viol_s = 1'b0;
        endcase
    end

    // Main handshake FSM with its arming, sample and fill counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            prep_cnt_q <= 16'd0;
            len_q      <= {LEN_W{1'b0}};
            smp_cnt_q  <= {LEN_W{1'b0}};
            fill_cnt_q <= {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ch_if.prepare) begin
                        state_q    <= ST_ARM;
                        len_q      <= ch_if.fill_len;
                        prep_cnt_q <= PREP_LOAD;
                    end
                end
                ST_ARM: begin
                    if (!ch_if.prepare) begin
                        state_q <= ST_IDLE;
                    end else if (prep_cnt_q == 16'd0) begin
                        state_q <= ST_READY;
                    end else begin
                        prep_cnt_q <= prep_cnt_q - 16'd1;
                    end
                end
                ST_READY: begin
                    if (ch_if.go && ch_if.pause) begin
                        if (len_q == {LEN_W{1'b0}}) begin
                            // Zero-length fill completes without any writes.
                            state_q    <= ST_DONE;
                            fill_cnt_q <= fill_cnt_q + CNT_W'(1);
                        end else begin
                            state_q   <= ST_FILL;
                            smp_cnt_q <= {LEN_W{1'b0}};
                        end
                    end else if (!ch_if.go && !ch_if.prepare) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (!ch_if.go) begin
                        // Aborted fill: partial data stays in the buffer.
                        state_q <= ST_IDLE;
                    end else if (write_s) begin
                        smp_cnt_q <= smp_cnt_q + LEN_W'(1);
                        if (last_s) begin
                            state_q    <= ST_DONE;
                            fill_cnt_q <= fill_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!ch_if.go) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flag; a violation in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (viol_s) begin
            err_q <= 1'b1;
        end else if (ch_if.err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign ch_if.ready       = (state_q == ST_READY);
    assign ch_if.done        = (state_q == ST_DONE);
    assign ch_if.busy        = (state_q != ST_IDLE);
    assign ch_if.sample_we   = write_s;
    assign ch_if.sample_addr = smp_cnt_q;
    assign ch_if.fill_count  = fill_cnt_q;
    assign ch_if.err         = err_q;

endmodule

// File: tb/tb_fill_responder.sv
// Self-checking bench for fill_responder: a flag-based behavioural model of
// the channel handshake checked every cycle, plus directed scenarios with
// hand-computed literal expectations.
module tb_fill_responder;

    localparam int PREP = 4;
    localparam int LW   = 16;
    localparam int CW   = 2;

    logic clk = 1'b0;
    logic rst_n;

    fill_responder_if #(.LEN_W(LW), .CNT_W(CW)) bus ();

    fill_responder #(.PREP_CYCLES(PREP), .LEN_W(LW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ch_if (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int we_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int          m_arm_left;   // -1 when not arming, else cycles still to wait
    bit          m_rdy, m_fill, m_done, m_err;
    int          m_written;
    logic [LW-1:0] m_len;
    logic [CW-1:0] m_fills;

    function automatic bit model_viol();
        if (m_done) return 1'b0;
        if (m_fill) return !bus.go || !bus.pause;
        if (m_rdy)  return bus.go && !bus.pause;
        if (m_arm_left >= 0) return bus.go;
        return bus.go && !bus.prepare;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_arm_left <= -1; m_rdy <= 1'b0; m_fill <= 1'b0; m_done <= 1'b0;
            m_err <= 1'b0; m_written <= 0; m_len <= '0; m_fills <= '0;
        end else begin
            if (model_viol()) m_err <= 1'b1;
            else if (bus.err_clr) m_err <= 1'b0;
            if (m_done) begin
                if (!bus.go) m_done <= 1'b0;
            end else if (m_fill) begin
                if (!bus.go) m_fill <= 1'b0;
                else if (bus.sample_valid) begin
                    m_written <= m_written + 1;
                    if (m_written + 1 == int'(m_len)) begin
                        m_fill <= 1'b0; m_done <= 1'b1; m_fills <= m_fills + 2'd1;
                    end
                end
            end else if (m_rdy) begin
                if (bus.go && bus.pause) begin
                    m_rdy <= 1'b0;
                    if (m_len == '0) begin m_done <= 1'b1; m_fills <= m_fills + 2'd1; end
                    else begin m_fill <= 1'b1; m_written <= 0; end
                end else if (!bus.go && !bus.prepare) m_rdy <= 1'b0;
            end else if (m_arm_left >= 0) begin
                if (!bus.prepare) m_arm_left <= -1;
                else if (m_arm_left == 0) begin m_arm_left <= -1; m_rdy <= 1'b1; end
                else m_arm_left <= m_arm_left - 1;
            end else if (bus.prepare) begin
                m_arm_left <= PREP - 1; m_len <= bus.fill_len;
            end
        end
    end

    // Count buffer writes as they are committed.
    always @(posedge clk) if (rst_n && bus.sample_we) we_cnt <= we_cnt + 1;

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        #2;
        check("ready", bus.ready, m_rdy);
        check("done", bus.done, m_done);
        check("busy", bus.busy, m_rdy | m_fill | m_done | (m_arm_left >= 0));
        check("sample_we", bus.sample_we, m_fill & bus.sample_valid & bus.go);
        check("err", bus.err, m_err);
        check("fill_count", bus.fill_count, m_fills);
        if (m_fill) check("sample_addr", bus.sample_addr, m_written[LW-1:0]);
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input bit p, input bit g, input bit pa, input bit sv, input bit ec);
        @(negedge clk);
        bus.prepare = p; bus.go = g; bus.pause = pa; bus.sample_valid = sv; bus.err_clr = ec;
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [LW-1:0] len);
        bus.fill_len = len;
        repeat (PREP + 1) step(1, 0, 0, 0, 0);
    endtask

    int w0;
    logic [CW-1:0] fc_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        rst_n = 1'b0;
        bus.prepare = 1'b0; bus.go = 1'b0; bus.pause = 1'b0;
        bus.sample_valid = 1'b0; bus.err_clr = 1'b0; bus.fill_len = '0;
        #12;
        check("rst_ready", bus.ready, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_addr", bus.sample_addr, 16'd0);
        check("rst_fc", bus.fill_count, 2'd0);
        @(negedge clk); rst_n = 1'b1;

        // 1: basic fill of 3 samples
        bus.fill_len = 16'd3;
        repeat (4) step(1, 0, 0, 0, 0);
        check("t1_ready_edge3", bus.ready, 1'b0);
        step(1, 0, 0, 0, 0);
        check("t1_ready_edge4", bus.ready, 1'b1);
        w0 = we_cnt;
        step(0, 1, 1, 1, 0);
        check("t1_fill_busy", bus.busy, 1'b1);
        step(0, 1, 1, 1, 0); step(0, 1, 1, 1, 0);
        check("t1_done_early", bus.done, 1'b0);
        step(0, 1, 1, 1, 0);
        check("t1_done", bus.done, 1'b1);
        check("t1_writes", we_cnt - w0, 3);
        step(0, 0, 1, 0, 0);
        check("t1_done_drop", bus.done, 1'b0);
        check("t1_fc", bus.fill_count, 2'd1);
        check("t1_model_fc", m_fills, 2'd1);
        check("t1_err", bus.err, 1'b0);

        // 2: length 5, sample_valid every other cycle
        arm(16'd5);
        w0 = we_cnt;
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1, (i % 2) == 0, 0);
        check("t2_done_early", bus.done, 1'b0);
        check("t2_writes4", we_cnt - w0, 4);
        step(0, 1, 1, 1, 0);
        check("t2_done", bus.done, 1'b1);
        check("t2_writes5", we_cnt - w0, 5);
        step(0, 0, 0, 0, 0);
        check("t2_fc", bus.fill_count, 2'd2);

        // 3a: prepare dropped during arming
        bus.fill_len = 16'd3;
        repeat (3) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("t3a_busy", bus.busy, 1'b0);
        repeat (5) step(0, 0, 0, 0, 0);
        check("t3a_ready", bus.ready, 1'b0);
        check("t3a_err", bus.err, 1'b0);

        // 3b: go dropped after 2 of 8 samples
        arm(16'd8);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0); step(0, 1, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        check("t3b_err", bus.err, 1'b1);
        check("t3b_busy", bus.busy, 1'b0);
        check("t3b_fc", bus.fill_count, 2'd2);
        step(0, 0, 0, 0, 1);
        check("t3b_err_clr", bus.err, 1'b0);

        // 4: zero-length fill
        arm(16'd0);
        w0 = we_cnt;
        step(0, 1, 1, 1, 0);
        check("t4_done", bus.done, 1'b1);
        check("t4_fc", bus.fill_count, 2'd3);
        step(0, 0, 0, 0, 0);
        check("t4_writes", we_cnt - w0, 0);

        // 5a: go in IDLE
        step(0, 1, 0, 0, 0);
        check("t5a_err", bus.err, 1'b1);
        check("t5a_busy", bus.busy, 1'b0);
        step(0, 0, 0, 0, 1);
        check("t5a_clr", bus.err, 1'b0);

        // 5b: go without pause in READY
        arm(16'd2);
        step(1, 1, 0, 0, 0);
        check("t5b_err", bus.err, 1'b1);
        check("t5b_ready", bus.ready, 1'b1);
        step(0, 0, 0, 0, 1);
        check("t5b_idle", bus.busy, 1'b0);
        check("t5b_clr", bus.err, 1'b0);

        // 6: asynchronous reset mid-fill, then wrap of fill_count
        arm(16'd8);
        step(0, 1, 1, 1, 0); step(0, 1, 1, 1, 0); step(0, 1, 1, 1, 0);
        check("t6_we_before", bus.sample_we, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_we", bus.sample_we, 1'b0);
        check("t6_rst_busy", bus.busy, 1'b0);
        check("t6_rst_done", bus.done, 1'b0);
        check("t6_rst_addr", bus.sample_addr, 16'd0);
        check("t6_rst_fc", bus.fill_count, 2'd0);
        bus.go = 1'b0; bus.pause = 1'b0; bus.sample_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int f = 0; f < 5; f++) begin
            arm(16'd1);
            step(0, 1, 1, 0, 0);
            step(0, 1, 1, 1, 0);
            check("t6_wrap_fc", bus.fill_count, fc_exp[f]);
            step(0, 0, 0, 0, 0);
        end

        repeat (2) step(0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
